// File: rtl/move_pkg.sv
// move_pkg: shared heading encoding, board geometry and FSM states for move_ctrl
package move_pkg;
    typedef enum logic [1:0] {DIR_L = 2'd0, DIR_R = 2'd1, DIR_U = 2'd2, DIR_D = 2'd3} dir_t;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_QUERY, S_DECIDE, S_STEP} state_t;
    localparam int unsigned X0   = 150;
    localparam int unsigned Y0   = 34;
    localparam int unsigned TILE = 60;
    localparam int unsigned COLS = 8;
    localparam int unsigned ROWS = 8;
    // idx*60 as (idx<<6)-(idx<<2), keeping multipliers off the position path
    function automatic logic [9:0] tile_base(input logic [2:0] idx);
        return (10'(idx) << 6) - (10'(idx) << 2);
    endfunction
endpackage

// File: rtl/move_tick.sv
// move_tick: step tick generator, counts 0..STEP_DIV-1 while en is high and pulses tick on the last count
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   en    in  count enable; the counter holds while low
//   tick  out one-cycle pulse at count STEP_DIV-1
module move_tick #(
    parameter int unsigned STEP_DIV = 833333
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int unsigned W = $clog2(STEP_DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = en && cnt_q == W'(STEP_DIV - 1);
    always_comb cnt_d = !en ? cnt_q : tick ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/move_ctrl.sv
// move_ctrl: tile-board sprite mover, steps one pixel per tick and turns only where the legal-move lookup allows
//   clk, rst_n                  clock, asynchronous active-low reset
//   game_en                     run enable; low freezes motion and the tick counter
//   btn_l/r/u/d                 level-high direction requests (priority L>R>U>D)
//   q_x, q_y                    query position sent to the legal-move lookup
//   leg_l/r/u/d                 lookup result, valid the cycle after the query
//   xpos, ypos                  sprite top-left pixel position
//   dir                         heading 0=L 1=R 2=U 3=D
//   moving                      high while the sprite advances
// Build option: MOVE_CTRL_REVERSE_EN lets an opposite request reverse mid-tile without a lookup.
module move_ctrl #(
    parameter int unsigned STEP_DIV  = 833333,
    parameter int unsigned START_COL = 3,
    parameter int unsigned START_ROW = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_en,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    output logic [9:0] q_x,
    output logic [9:0] q_y,
    input  logic       leg_l,
    input  logic       leg_r,
    input  logic       leg_u,
    input  logic       leg_d,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [1:0] dir,
    output logic       moving
);
    import move_pkg::*;
    localparam logic [5:0] OFF_MAX = 6'(TILE - 1);
    localparam logic [9:0] X_RST   = 10'(X0 + START_COL * TILE);
    localparam logic [9:0] Y_RST   = 10'(Y0 + START_ROW * TILE);
    state_t     state_q, state_d;
    logic [2:0] col_q, col_d, row_q, row_d;
    logic [5:0] x_off_q, x_off_d, y_off_q, y_off_d;
    dir_t       dir_q, dir_d, pend_q, pend_d;
    logic       mov_q, mov_d;
    logic [9:0] qx_q, qx_d, qy_q, qy_d;
    logic       tick, aligned;
    logic [3:0] leg;

    move_tick #(.STEP_DIV(STEP_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .en(game_en), .tick(tick));

    assign aligned = x_off_q == '0 && y_off_q == '0;
    assign leg     = {leg_d, leg_u, leg_r, leg_l};
    assign xpos    = 10'(X0) + tile_base(col_q) + 10'(x_off_q);
    assign ypos    = 10'(Y0) + tile_base(row_q) + 10'(y_off_q);
    assign q_x     = qx_q;
    assign q_y     = qy_q;
    assign dir     = dir_q;
    assign moving  = mov_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        x_off_d = x_off_q;
        y_off_d = y_off_q;
        dir_d   = dir_q;
        mov_d   = mov_q;
        pend_d  = btn_l ? DIR_L : btn_r ? DIR_R : btn_u ? DIR_U : btn_d ? DIR_D : pend_q;
        if (!game_en) state_d = S_IDLE;
        else begin
            case (state_q)
                S_IDLE:   state_d = S_WAIT;
                S_WAIT:   if (tick) state_d = aligned ? S_QUERY : S_STEP;
                S_QUERY:  state_d = S_DECIDE;
                S_DECIDE: begin
                    state_d = S_STEP;
                    dir_d   = leg[pend_q] ? pend_q : dir_q;
                    mov_d   = leg[pend_q] | leg[dir_q];
                end
                S_STEP: begin
                    state_d = S_WAIT;
`ifdef MOVE_CTRL_REVERSE_EN
                    if (!aligned && pend_q == dir_t'(dir_q ^ 2'd1)) dir_d = pend_q;
`endif
                    // offsets wrap across the tile edge, carrying into col/row
                    if (mov_q) begin
                        x_off_d = dir_d == DIR_R ? (x_off_q == OFF_MAX ? '0 : x_off_q + 6'd1)
                                : dir_d == DIR_L ? (x_off_q == '0 ? OFF_MAX : x_off_q - 6'd1) : x_off_q;
                        col_d   = dir_d == DIR_R && x_off_q == OFF_MAX ? col_q + 3'd1
                                : dir_d == DIR_L && x_off_q == '0 ? col_q - 3'd1 : col_q;
                        y_off_d = dir_d == DIR_D ? (y_off_q == OFF_MAX ? '0 : y_off_q + 6'd1)
                                : dir_d == DIR_U ? (y_off_q == '0 ? OFF_MAX : y_off_q - 6'd1) : y_off_q;
                        row_d   = dir_d == DIR_D && y_off_q == OFF_MAX ? row_q + 3'd1
                                : dir_d == DIR_U && y_off_q == '0 ? row_q - 3'd1 : row_q;
                    end
                end
                default:  state_d = S_IDLE;
            endcase
        end
        // position is stable from QUERY entry until STEP, so loading here keeps q equal to xpos/ypos in QUERY
        qx_d = state_d == S_QUERY ? xpos : qx_q;
        qy_d = state_d == S_QUERY ? ypos : qy_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= 3'(START_COL);
            row_q   <= 3'(START_ROW);
            x_off_q <= '0;
            y_off_q <= '0;
            dir_q   <= DIR_L;
            pend_q  <= DIR_L;
            mov_q   <= 1'b0;
            qx_q    <= X_RST;
            qy_q    <= Y_RST;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_off_q <= x_off_d;
            y_off_q <= y_off_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            mov_q   <= mov_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
        end
endmodule

// File: tb/tb_move_ctrl.sv
// tb_move_ctrl: directed table, hand-written corner sequences and a randomized run against a per-tick pixel model
module tb_move_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, game_en = 1'b0;
    logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic leg_l = 1'b0, leg_r = 1'b0, leg_u = 1'b0, leg_d = 1'b0;
    logic [9:0] q_x, q_y, xpos, ypos;
    logic [1:0] dir;
    logic moving;
    int checks = 0, failures = 0;
    int px, py, md, mm, mp, mqx, mqy;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] leg;
        int n;
        int ex, ey, ed, em, eqx;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    move_ctrl #(.STEP_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .game_en(game_en),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .q_x(q_x), .q_y(q_y),
        .leg_l(leg_l), .leg_r(leg_r), .leg_u(leg_u), .leg_d(leg_d),
        .xpos(xpos), .ypos(ypos), .dir(dir), .moving(moving)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ex, input int ey, input int ed, input int em,
                           input int eqx, input int eqy);
        chk({tag, ".xpos"}, 32'(xpos), ex);
        chk({tag, ".ypos"}, 32'(ypos), ey);
        chk({tag, ".dir"}, 32'(dir), ed);
        chk({tag, ".moving"}, 32'(moving), em);
        chk({tag, ".q_x"}, 32'(q_x), eqx);
        chk({tag, ".q_y"}, 32'(q_y), eqy);
    endtask

    // leaves the bench at the falling edge just before the first tick edge
    task automatic do_reset();
        rst_n = 1'b0;
        game_en = 1'b0;
        {btn_l, btn_r, btn_u, btn_d} = 4'b0;
        {leg_l, leg_r, leg_u, leg_d} = 4'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("reset", 330, 394, 0, 0, 330, 394);
        rst_n = 1'b1;
        game_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    // one tick period: button pulse latched on the tick edge, lookup held for the whole period
    task automatic run_tick(input logic [3:0] b, input logic [3:0] lg);
        {btn_l, btn_r, btn_u, btn_d} = b;
        {leg_l, leg_r, leg_u, leg_d} = lg;
        @(posedge clk);
        @(negedge clk);
        {btn_l, btn_r, btn_u, btn_d} = 4'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_tick(input logic [3:0] b, input logic [3:0] lg);
        if (b[3]) mp = 0;
        else if (b[2]) mp = 1;
        else if (b[1]) mp = 2;
        else if (b[0]) mp = 3;
        if ((px - 150) % 60 == 0 && (py - 34) % 60 == 0) begin
            mqx = px;
            mqy = py;
            if (lg[3 - mp]) begin
                md = mp;
                mm = 1;
            end else mm = int'(lg[3 - md]);
        end
`ifdef MOVE_CTRL_REVERSE_EN
        else if (mp == (md ^ 1)) md = mp;
`endif
        if (mm != 0) begin
            case (md)
                0: px--;
                1: px++;
                2: py--;
                default: py++;
            endcase
        end
    endtask

    initial begin
        tbl[0] = '{4'b1000, 4'b1100, 1, 329, 394, 0, 1, 330};
        tbl[1] = '{4'b0000, 4'b1100, 59, 270, 394, 0, 1, 330};
        tbl[2] = '{4'b0010, 4'b1000, 1, 269, 394, 0, 1, 270};
        tbl[3] = '{4'b0000, 4'b1000, 59, 210, 394, 0, 1, 270};
        tbl[4] = '{4'b0000, 4'b0000, 3, 210, 394, 0, 0, 210};
        tbl[5] = '{4'b0101, 4'b0101, 1, 211, 394, 1, 1, 210};
        tbl[6] = '{4'b0000, 4'b0101, 29, 240, 394, 1, 1, 210};
`ifdef MOVE_CTRL_REVERSE_EN
        tbl[7] = '{4'b1000, 4'b0000, 1, 239, 394, 0, 1, 210};
        tbl[8] = '{4'b0000, 4'b0000, 29, 210, 394, 0, 1, 210};
        tbl[9] = '{4'b0000, 4'b0000, 2, 210, 394, 0, 0, 210};
`else
        tbl[7] = '{4'b1000, 4'b0000, 1, 241, 394, 1, 1, 210};
        tbl[8] = '{4'b0000, 4'b0000, 29, 270, 394, 1, 1, 210};
        tbl[9] = '{4'b0000, 4'b0000, 2, 270, 394, 1, 0, 270};
`endif
        do_reset();
        foreach (tbl[r]) begin
            for (int i = 0; i < tbl[r].n; i++) run_tick(i == 0 ? tbl[r].btn : 4'b0, tbl[r].leg);
            chk_out($sformatf("row%0d", r), tbl[r].ex, tbl[r].ey, tbl[r].ed, tbl[r].em, tbl[r].eqx, 394);
        end

        // freeze mid-tile, resume, then asynchronous reset while frozen
        do_reset();
        for (int i = 0; i < 10; i++) run_tick(i == 0 ? 4'b1000 : 4'b0, 4'b1100);
        chk_out("pre_freeze", 320, 394, 0, 1, 330, 394);
        game_en = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("freeze.xpos", 32'(xpos), 320);
        chk("freeze.dir", 32'(dir), 0);
        game_en = 1'b1;
        for (int i = 0; i < 40 && xpos !== 10'd319; i++) @(negedge clk);
        chk("resume.xpos", 32'(xpos), 319);
        game_en = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_out("async_frozen", 330, 394, 0, 0, 330, 394);
        do_reset();
        run_tick(4'b1000, 4'b1100);
        chk_out("restart", 329, 394, 0, 1, 330, 394);

        // reset landing in STEP discards the pending pixel
        do_reset();
        {btn_l, btn_r, btn_u, btn_d} = 4'b1000;
        {leg_l, leg_r, leg_u, leg_d} = 4'b1100;
        @(posedge clk);
        {btn_l, btn_r, btn_u, btn_d} = 4'b0;
        repeat (2) @(posedge clk);
        #2 chk("decided.moving", 32'(moving), 1);
        rst_n = 1'b0;
        #1 chk_out("async_step", 330, 394, 0, 0, 330, 394);
        @(posedge clk);
        #1 chk_out("held_step", 330, 394, 0, 0, 330, 394);
        do_reset();
        run_tick(4'b1000, 4'b1100);
        chk_out("restart2", 329, 394, 0, 1, 330, 394);

        // randomized run against the per-tick model
        do_reset();
        px = 330; py = 394; md = 0; mm = 0; mp = 0; mqx = 330; mqy = 394;
        for (int t = 0; t < 300; t++) begin
            logic [3:0] b, lg;
            int col, row;
            col = (px - 150) / 60;
            row = (py - 34) / 60;
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            lg = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            if (col == 0) lg[3] = 1'b0;
            if (col == 7) lg[2] = 1'b0;
            if (row == 0) lg[1] = 1'b0;
            if (row == 7) lg[0] = 1'b0;
            run_tick(b, lg);
            model_tick(b, lg);
            chk_out($sformatf("rand%0d", t), px, py, md, mm, mqx, mqy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
